line_burst_adapter: RTL and testbench
=====================================

LINE_BURST_ADAPTER -- requirements
Module: line_burst_adapter

Interface
REQ-001 SHALL have parameter BURST_W, default 64, giving the memory-side beat width in bits.
REQ-002 SHALL have parameter BURSTS, default 4, giving beats per line; BURST_W*BURSTS SHALL equal 256.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port line_i, input, 256, write-back line from the cache (the cache's pmem_wdata).
REQ-006 SHALL have port line_o, output, 256, assembled fill line to the cache (the cache's pmem_rdata).
REQ-007 SHALL have port address_i, input, 32, line address from the cache.
REQ-008 SHALL have ports read_i and write_i, input, 1 each, line read and line write requests.
REQ-009 SHALL have port resp_o, output, 1, line transfer complete.
REQ-010 SHALL have port burst_i, input, BURST_W, read beat from memory.
REQ-011 SHALL have port burst_o, output, BURST_W, write beat to memory.
REQ-012 SHALL have port address_o, output, 32, burst start address to memory.
REQ-013 SHALL have ports read_o and write_o, output, 1 each, burst requests to memory.
REQ-014 SHALL have port resp_i, input, 1, one beat accepted or delivered by memory.

Function
REQ-015 FSM states SHALL be IDLE, READ, WRITE, DONE.
REQ-016 In IDLE with write_i=1: latch line_i and address_i, beat counter=0, go to WRITE; write_i has priority if read_i is also 1.
REQ-017 In IDLE with read_i=1 and write_i=0: latch address_i, beat counter=0, go to READ.
REQ-018 address_o SHALL be the latched address with bits [4:0] forced to 0, stable for the whole burst.
REQ-019 read_o SHALL be 1 exactly while in READ; write_o SHALL be 1 exactly while in WRITE.
REQ-020 In READ, on each cycle with resp_i=1: store burst_i into line beat k (bits k*64+63:k*64, k = counter, beat 0 lowest) and increment the counter.
REQ-021 In WRITE, burst_o SHALL equal latched line beat k; on each cycle with resp_i=1, increment k.
REQ-022 Cycles with resp_i=0 in READ/WRITE SHALL hold all state; gaps between beats are legal.
REQ-023 On acceptance of beat BURSTS-1, go to DONE on the next edge.
REQ-024 DONE SHALL last exactly one cycle with resp_o=1, then return to IDLE; resp_o SHALL be 0 in every other state.
REQ-025 line_o SHALL hold the last assembled line until the next READ overwrites beat 0.
REQ-026 read_i/write_i SHALL be ignored outside IDLE, including in DONE.
REQ-027 resp_i in IDLE or DONE SHALL be ignored.
REQ-028 Minimum latency request-to-resp_o SHALL be BURSTS+2 cycles (resp_i high every cycle).

Reset
REQ-029 rst=0 SHALL immediately force state IDLE, counter 0, read_o=0, write_o=0, resp_o=0, line_o=0, burst_o=0, address_o=0.
REQ-030 Reset asserted mid-burst SHALL abort the transfer with no resp_o; the first request after release starts a fresh burst.

Structure
REQ-031 State enum and BURSTS/BURST_W defaults SHALL live in the shared sched_structs package.
REQ-032 Single module; no sub-module is needed (counter and beat mux are inline).

Verification
REQ-033 Read: address_i=0x0000_1234, read_i=1, resp_i high 4 cycles with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x0000_1220, line_o={0x44..,0x33..,0x22..,0x11..}, resp_o pulses once at cycle 6.
REQ-034 Write: line_i=256'h(beats D3,D2,D1,D0), write_i=1 -> burst_o presents D0,D1,D2,D3 in order, write_o drops after 4th resp_i, single resp_o pulse.
REQ-035 Stalled read: resp_i pattern 1,0,0,1,1,0,1 -> beats stored only on high cycles, resp_o once after 7th cycle, read_o held throughout.
REQ-036 Simultaneous read_i=1 and write_i=1 in IDLE -> WRITE burst performed, read_o never asserted.
REQ-037 rst=0 after 2 read beats -> outputs zero asynchronously, no resp_o; next read completes correctly with all 4 beats fresh.
REQ-038 Request held high through DONE -> exactly one new burst starts from IDLE, not from DONE.

Source files
------------

// File: rtl/sched_structs.sv
// Shared scheduling types: line-burst adapter state encoding and beat geometry.
package sched_structs;

  localparam int LINE_W      = 256;
  localparam int BURST_W_DEF = 64;
  localparam int BURSTS_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lba_state_e;

endpackage

// File: rtl/line_burst_adapter.sv
// Bridges a 256-bit cache line port to a narrower burst memory port,
// splitting write-backs into beats and assembling fills from beats.
module line_burst_adapter
  import sched_structs::*;
#(
  parameter int BURST_W = BURST_W_DEF,
  parameter int BURSTS  = BURSTS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int              CNT_W       = (BURSTS > 1) ? $clog2(BURSTS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BURSTS - 1);
  localparam logic [31:0]     LINE_MASK   = ~32'h0000_001F;

  lba_state_e state_reg, state_next;

  logic [CNT_W-1:0]   cnt_reg;
  logic [LINE_W-1:0]  wline_reg;
  logic [LINE_W-1:0]  rline_reg;
  logic [31:0]        addr_reg;
  logic               beat_accept;
  logic               start_req;
  logic [BURST_W-1:0] wbeat [BURSTS];

  // Slice the latched write-back line into beats, beat 0 in the low bits.
  generate
    for (genvar gi = 0; gi < BURSTS; gi++) begin : g_wbeat
      assign wbeat[gi] = wline_reg[gi*BURST_W +: BURST_W];
    end
  endgenerate

  assign start_req = (state_reg == IDLE) && (read_i || write_i);

  always_comb begin
    state_next  = state_reg;
    read_o      = 1'b0;
    write_o     = 1'b0;
    resp_o      = 1'b0;
    beat_accept = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (write_i)     state_next = WRITE;
        else if (read_i) state_next = READ;
      end
      READ: begin
        read_o      = 1'b1;
        beat_accept = resp_i;
        if (resp_i && (cnt_reg == LAST_BEAT)) state_next = DONE;
      end
      WRITE: begin
        write_o     = 1'b1;
        beat_accept = resp_i;
        if (resp_i && (cnt_reg == LAST_BEAT)) state_next = DONE;
      end
      DONE: begin
        // Requests seen here are deliberately dropped; the cache re-requests from IDLE.
        resp_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg   <= '0;
      wline_reg <= '0;
      rline_reg <= '0;
      addr_reg  <= '0;
    end else begin
      if (start_req) begin
        addr_reg <= address_i & LINE_MASK;
        cnt_reg  <= '0;
        if (write_i) wline_reg <= line_i;
      end
      if (beat_accept) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
        if (state_reg == READ) rline_reg[cnt_reg*BURST_W +: BURST_W] <= burst_i;
      end
    end
  end

  assign line_o    = rline_reg;
  assign burst_o   = wbeat[cnt_reg];
  assign address_o = addr_reg;

endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed self-checking bench for line_burst_adapter.
module tb_line_burst_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  int errors = 0;
  int checks = 0;

  logic [255:0] last_line;

  line_burst_adapter #(.BURST_W(64), .BURSTS(4)) dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    line_i = '1; address_i = 32'hFFFF_FFFF; burst_i = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000", {read_o, write_o, resp_o});
    end
    checks++;
    if (line_o !== '0) begin
      errors++; $display("FAIL reset_line_o: got %h expected 0", line_o);
    end
    checks++;
    if (burst_o !== '0 || address_o !== '0) begin
      errors++; $display("FAIL reset_mem_side: got burst_o=%h address_o=%h expected 0/0", burst_o, address_o);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (read_o !== 1'b0 || write_o !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: got read_o=%b write_o=%b expected 0/0", read_o, write_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_read();
    logic [63:0]  rb [4];
    logic [255:0] exp;
    rb[0] = 64'h1111111111111111; rb[1] = 64'h2222222222222222;
    rb[2] = 64'h3333333333333333; rb[3] = 64'h4444444444444444;
    exp = {rb[3], rb[2], rb[1], rb[0]};
    // resp_i while idle must not start anything or store data
    resp_i = 1'b1; burst_i = 64'h0BAD0BAD0BAD0BAD;
    @(negedge clk);
    checks++;
    if (read_o !== 1'b0 || line_o !== '0) begin
      errors++; $display("FAIL idle_resp_ignored: got read_o=%b line_o=%h expected 0/0", read_o, line_o);
    end
    resp_i = 1'b0; address_i = 32'h0000_1234; read_i = 1'b1;
    @(negedge clk);
    read_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (read_o !== 1'b1 || resp_o !== 1'b0 || write_o !== 1'b0) begin
        errors++; $display("FAIL read_ctrl_beat%0d: got read_o=%b write_o=%b resp_o=%b expected 1/0/0", k, read_o, write_o, resp_o);
      end
      checks++;
      if (address_o !== 32'h0000_1220) begin
        errors++; $display("FAIL read_address_beat%0d: got %h expected 00001220", k, address_o);
      end
      resp_i = 1'b1; burst_i = rb[k];
      @(negedge clk);
    end
    checks++;
    if (resp_o !== 1'b1 || read_o !== 1'b0) begin
      errors++; $display("FAIL read_done: got resp_o=%b read_o=%b expected 1/0", resp_o, read_o);
    end
    checks++;
    if (line_o !== exp) begin
      errors++; $display("FAIL read_line: got %h expected %h", line_o, exp);
    end
    resp_i = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_o !== 1'b0 || line_o !== exp) begin
      errors++; $display("FAIL read_after_done: got resp_o=%b line_o=%h expected 0/%h", resp_o, line_o, exp);
    end
    last_line = exp;
    $display("test_read done");
  endtask

  task automatic test_write();
    logic [63:0] d [4];
    d[0] = 64'h0123456789ABCDEF; d[1] = 64'hFEDCBA9876543210;
    d[2] = 64'hDEADBEEFCAFEF00D; d[3] = 64'h0F1E2D3C4B5A6978;
    line_i = {d[3], d[2], d[1], d[0]}; address_i = 32'h8000_003F; write_i = 1'b1;
    @(negedge clk);
    write_i = 1'b0; line_i = '0;
    checks++;
    if (address_o !== 32'h8000_0020) begin
      errors++; $display("FAIL write_address: got %h expected 80000020", address_o);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (write_o !== 1'b1 || read_o !== 1'b0 || resp_o !== 1'b0) begin
        errors++; $display("FAIL write_ctrl_beat%0d: got write_o=%b read_o=%b resp_o=%b expected 1/0/0", k, write_o, read_o, resp_o);
      end
      checks++;
      if (burst_o !== d[k]) begin
        errors++; $display("FAIL write_data_beat%0d: got %h expected %h", k, burst_o, d[k]);
      end
      if (k == 1) begin
        resp_i = 1'b0;
        @(negedge clk);
        checks++;
        if (burst_o !== d[1] || write_o !== 1'b1) begin
          errors++; $display("FAIL write_stall_hold: got burst_o=%h write_o=%b expected %h/1", burst_o, write_o, d[1]);
        end
      end
      resp_i = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (resp_o !== 1'b1 || write_o !== 1'b0) begin
      errors++; $display("FAIL write_done: got resp_o=%b write_o=%b expected 1/0", resp_o, write_o);
    end
    checks++;
    if (line_o !== last_line) begin
      errors++; $display("FAIL write_keeps_line_o: got %h expected %h", line_o, last_line);
    end
    resp_i = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_o !== 1'b0) begin
      errors++; $display("FAIL write_single_pulse: got resp_o=%b expected 0", resp_o);
    end
    $display("test_write done");
  endtask

  task automatic test_stalled_read();
    logic [63:0]  sb [4];
    logic         p [7];
    logic [255:0] exp;
    int           j;
    sb[0] = 64'h5555AAAA5555AAAA; sb[1] = 64'h6666000066660000;
    sb[2] = 64'h77777777FFFFFFFF; sb[3] = 64'h8888123488885678;
    p = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp = {sb[3], sb[2], sb[1], sb[0]};
    address_i = 32'h0000_0FFF; read_i = 1'b1;
    @(negedge clk);
    read_i = 1'b0;
    j = 0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (read_o !== 1'b1 || resp_o !== 1'b0) begin
        errors++; $display("FAIL stall_ctrl_cycle%0d: got read_o=%b resp_o=%b expected 1/0", i, read_o, resp_o);
      end
      resp_i = p[i];
      burst_i = p[i] ? sb[j] : 64'hDEADDEADDEADDEAD;
      if (p[i]) j++;
      @(negedge clk);
    end
    checks++;
    if (resp_o !== 1'b1 || address_o !== 32'h0000_0FE0) begin
      errors++; $display("FAIL stall_done: got resp_o=%b address_o=%h expected 1/00000fe0", resp_o, address_o);
    end
    checks++;
    if (line_o !== exp) begin
      errors++; $display("FAIL stall_line: got %h expected %h", line_o, exp);
    end
    resp_i = 1'b0;
    @(negedge clk);
    last_line = exp;
    $display("test_stalled_read done");
  endtask

  task automatic test_simultaneous();
    logic [63:0] d [4];
    d[0] = 64'hA0A0A0A0A0A0A0A0; d[1] = 64'hB1B1B1B1B1B1B1B1;
    d[2] = 64'hC2C2C2C2C2C2C2C2; d[3] = 64'hD3D3D3D3D3D3D3D3;
    line_i = {d[3], d[2], d[1], d[0]}; address_i = 32'h0000_0100;
    read_i = 1'b1; write_i = 1'b1;
    @(negedge clk);
    read_i = 1'b0; write_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (write_o !== 1'b1 || read_o !== 1'b0 || burst_o !== d[k]) begin
        errors++; $display("FAIL simul_beat%0d: got write_o=%b read_o=%b burst_o=%h expected 1/0/%h", k, write_o, read_o, burst_o, d[k]);
      end
      resp_i = 1'b1; burst_i = 64'hFFFFFFFFFFFFFFFF;
      @(negedge clk);
    end
    checks++;
    if (resp_o !== 1'b1 || read_o !== 1'b0 || line_o !== last_line) begin
      errors++; $display("FAIL simul_done: got resp_o=%b read_o=%b line_o=%h expected 1/0/%h", resp_o, read_o, line_o, last_line);
    end
    resp_i = 1'b0;
    @(negedge clk);
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0]  f [4];
    logic [255:0] exp;
    f[0] = 64'hF0F0F0F00F0F0F0F; f[1] = 64'hF1F1F1F11F1F1F1F;
    f[2] = 64'hF2F2F2F22F2F2F2F; f[3] = 64'hF3F3F3F33F3F3F3F;
    exp = {f[3], f[2], f[1], f[0]};
    address_i = 32'h0000_0040; read_i = 1'b1;
    @(negedge clk);
    read_i = 1'b0; resp_i = 1'b1; burst_i = 64'h9999999999999999;
    @(negedge clk);
    burst_i = 64'h7777777777777777;
    @(negedge clk);
    resp_i = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== '0) begin
      errors++; $display("FAIL async_reset_ctrl: got ctrl=%b line_o=%h expected 000/0", {read_o, write_o, resp_o}, line_o);
    end
    checks++;
    if (address_o !== '0 || burst_o !== '0) begin
      errors++; $display("FAIL async_reset_mem: got address_o=%h burst_o=%h expected 0/0", address_o, burst_o);
    end
    @(negedge clk);
    checks++;
    if (resp_o !== 1'b0) begin
      errors++; $display("FAIL reset_no_resp: got %b expected 0", resp_o);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (read_o !== 1'b0) begin
      errors++; $display("FAIL reset_stays_idle: got read_o=%b expected 0", read_o);
    end
    address_i = 32'h0000_2468; read_i = 1'b1;
    @(negedge clk);
    read_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (read_o !== 1'b1) begin
        errors++; $display("FAIL fresh_read_beat%0d: got read_o=%b expected 1", k, read_o);
      end
      resp_i = 1'b1; burst_i = f[k];
      @(negedge clk);
    end
    checks++;
    if (resp_o !== 1'b1 || line_o !== exp || address_o !== 32'h0000_2460) begin
      errors++; $display("FAIL fresh_read_done: got resp_o=%b address_o=%h line_o=%h expected 1/00002460/%h", resp_o, address_o, line_o, exp);
    end
    resp_i = 1'b0;
    @(negedge clk);
    $display("test_reset_mid_burst done");
  endtask

  task automatic test_held_request();
    logic [63:0]  h [4];
    logic [63:0]  g [4];
    logic [255:0] exp1, exp2;
    h[0] = 64'h1000000000000001; h[1] = 64'h2000000000000002;
    h[2] = 64'h3000000000000003; h[3] = 64'h4000000000000004;
    g[0] = 64'h00000000000000A1; g[1] = 64'h00000000000000B2;
    g[2] = 64'h00000000000000C3; g[3] = 64'h00000000000000D4;
    exp1 = {h[3], h[2], h[1], h[0]};
    exp2 = {g[3], g[2], g[1], g[0]};
    address_i = 32'h0000_3000; read_i = 1'b1; resp_i = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (read_o !== 1'b1 || resp_o !== 1'b0) begin
        errors++; $display("FAIL held_first_beat%0d: got read_o=%b resp_o=%b expected 1/0", k, read_o, resp_o);
      end
      burst_i = h[k];
      @(negedge clk);
    end
    checks++;
    if (resp_o !== 1'b1 || read_o !== 1'b0 || line_o !== exp1) begin
      errors++; $display("FAIL held_first_done: got resp_o=%b read_o=%b line_o=%h expected 1/0/%h", resp_o, read_o, line_o, exp1);
    end
    @(negedge clk);
    checks++;
    if (read_o !== 1'b0 || resp_o !== 1'b0) begin
      errors++; $display("FAIL held_idle_gap: got read_o=%b resp_o=%b expected 0/0", read_o, resp_o);
    end
    @(negedge clk);
    read_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (read_o !== 1'b1 || resp_o !== 1'b0) begin
        errors++; $display("FAIL held_second_beat%0d: got read_o=%b resp_o=%b expected 1/0", k, read_o, resp_o);
      end
      burst_i = g[k];
      @(negedge clk);
    end
    checks++;
    if (resp_o !== 1'b1 || line_o !== exp2) begin
      errors++; $display("FAIL held_second_done: got resp_o=%b line_o=%h expected 1/%h", resp_o, line_o, exp2);
    end
    resp_i = 1'b0;
    @(negedge clk);
    checks++;
    if (read_o !== 1'b0 || resp_o !== 1'b0) begin
      errors++; $display("FAIL held_no_third: got read_o=%b resp_o=%b expected 0/0", read_o, resp_o);
    end
    $display("test_held_request done");
  endtask

  initial begin
    last_line = '0;
    test_reset();
    test_read();
    test_write();
    test_stalled_read();
    test_simultaneous();
    test_reset_mid_burst();
    test_held_request();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
